// File: rtl/fll_cfg_slave.sv
// fll_cfg_slave -- FLL-side responder for the 4-phase req/ack configuration
// handshake issued by the APB FLL bridge. Synchronizes req into the FLL
// reference-clock domain, serves the 4-entry config/status register file and
// runs the lock detector.
//
// Optional feature macro: FLL_CFG_INTEG_WR_EN
//   defined   : a write to register 3 pulses integ_load_o for one cycle and
//               presents data_i on integ_load_data_o (held afterwards).
//   undefined : writes to register 3 are acked and ignored; integ_load_o and
//               integ_load_data_o are tied to 0.
//
// Ports:
//   HCLK, HRESETn         reference clock, async active-low reset
//   req_i/wrn_i/add_i/data_i  request from the bridge (req_i asynchronous)
//   ack_o, r_data_o       registered acknowledge and read data
//   lock_o                registered lock indication
//   meas_cnt_i/meas_valid_i   measured DCO periods per ref period + strobe
//   integ_i               current loop integrator (readable at register 3)
//   integ_load_o/integ_load_data_o  integrator load strobe and value
//   mult_o, dco_code_o, clk_div_o, open_loop_o, mode_o  CFG1 fields
//   gain_o                CFG2[3:0]
module fll_cfg_slave #(
  parameter logic [31:0] CFG1_RST = 32'h0000_05F5,
  parameter logic [31:0] CFG2_RST = 32'h0040_0C44
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_i,
  input  logic        wrn_i,
  input  logic [1:0]  add_i,
  input  logic [31:0] data_i,
  output logic        ack_o,
  output logic [31:0] r_data_o,
  output logic        lock_o,
  input  logic [15:0] meas_cnt_i,
  input  logic        meas_valid_i,
  input  logic [31:0] integ_i,
  output logic        integ_load_o,
  output logic [31:0] integ_load_data_o,
  output logic [15:0] mult_o,
  output logic [9:0]  dco_code_o,
  output logic [3:0]  clk_div_o,
  output logic        open_loop_o,
  output logic        mode_o,
  output logic [3:0]  gain_o
);

  typedef enum logic {IDLE, ACK} state_e;

  state_e      state_q;
  logic        req_meta_q, req_s_q;
  logic        ack_q, lock_q, lock_d;
  logic [31:0] r_data_q, rd_mux;
  logic [31:0] cfg1_q, cfg2_q;
  logic [15:0] meas_q;
  logic [5:0]  hit_q, hit_d, miss_q, miss_d;
  logic [5:0]  hit_inc, miss_inc, assert_thr, deassert_thr;
  logic [16:0] diff;
  logic        in_tol;

  // Two-flop synchronizer for the asynchronous request.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
    end else begin
      req_meta_q <= req_i;
      req_s_q    <= req_meta_q;
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (add_i)
      2'd0: rd_mux = {15'h0, lock_q, meas_q};
      2'd1: rd_mux = cfg1_q;
      2'd2: rd_mux = cfg2_q;
      2'd3: rd_mux = integ_i;
      default: rd_mux = 32'h0;
    endcase
  end

`ifdef FLL_CFG_INTEG_WR_EN
  logic        integ_load_q;
  logic [31:0] integ_load_data_q;
`endif

  // Handshake FSM: the access is executed on the IDLE->ACK edge, so read data
  // and register updates are in place by the time ack_o is seen high.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      r_data_q <= 32'h0;
      cfg1_q   <= CFG1_RST;
      cfg2_q   <= {4'h0, CFG2_RST[27:0]};
`ifdef FLL_CFG_INTEG_WR_EN
      integ_load_q      <= 1'b0;
      integ_load_data_q <= 32'h0;
`endif
    end else begin
`ifdef FLL_CFG_INTEG_WR_EN
      integ_load_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_s_q) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            if (wrn_i) begin
              r_data_q <= rd_mux;
            end else begin
              case (add_i)
                2'd1: cfg1_q <= data_i;
                2'd2: cfg2_q <= {4'h0, data_i[27:0]};
`ifdef FLL_CFG_INTEG_WR_EN
                2'd3: begin
                  integ_load_q      <= 1'b1;
                  integ_load_data_q <= data_i;
                end
`endif
                default: ;
              endcase
            end
          end
        end
        ACK: begin
          if (!req_s_q) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FLL_CFG_INTEG_WR_EN
  assign integ_load_o      = integ_load_q;
  assign integ_load_data_o = integ_load_data_q;
`else
  assign integ_load_o      = 1'b0;
  assign integ_load_data_o = 32'h0;
`endif

  // Lock detector. Uses registered mult/tol, so a CFG write landing in the
  // same cycle as a strobe only affects later evaluations.
  always_comb begin
    if (meas_cnt_i >= mult_o) diff = {1'b0, meas_cnt_i} - {1'b0, mult_o};
    else                      diff = {1'b0, mult_o} - {1'b0, meas_cnt_i};
  end

  assign in_tol       = (diff <= {5'h0, cfg2_q[27:16]});
  assign assert_thr   = (cfg2_q[9:4]   == 6'd0) ? 6'd1 : cfg2_q[9:4];
  assign deassert_thr = (cfg2_q[15:10] == 6'd0) ? 6'd1 : cfg2_q[15:10];
  assign hit_inc      = (hit_q  == 6'd63) ? hit_q  : hit_q  + 6'd1;
  assign miss_inc     = (miss_q == 6'd63) ? miss_q : miss_q + 6'd1;

  always_comb begin
    lock_d = lock_q;
    hit_d  = hit_q;
    miss_d = miss_q;
    if (open_loop_o) begin
      lock_d = 1'b0;
      hit_d  = 6'd0;
      miss_d = 6'd0;
    end else if (meas_valid_i) begin
      if (!lock_q) begin
        if (!in_tol)                   hit_d = 6'd0;
        else if (hit_inc >= assert_thr) begin
          lock_d = 1'b1;
          hit_d  = 6'd0;
        end else                       hit_d = hit_inc;
      end else begin
        if (in_tol)                       miss_d = 6'd0;
        else if (miss_inc >= deassert_thr) begin
          lock_d = 1'b0;
          miss_d = 6'd0;
        end else                          miss_d = miss_inc;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      lock_q <= 1'b0;
      hit_q  <= 6'd0;
      miss_q <= 6'd0;
      meas_q <= 16'h0;
    end else begin
      lock_q <= lock_d;
      hit_q  <= hit_d;
      miss_q <= miss_d;
      if (meas_valid_i) meas_q <= meas_cnt_i;
    end
  end

  assign ack_o       = ack_q;
  assign r_data_o    = r_data_q;
  assign lock_o      = lock_q;
  assign mult_o      = cfg1_q[15:0];
  assign dco_code_o  = cfg1_q[25:16];
  assign clk_div_o   = cfg1_q[29:26];
  assign open_loop_o = cfg1_q[30];
  assign mode_o      = cfg1_q[31];
  assign gain_o      = cfg2_q[3:0];

endmodule

// File: tb/tb_fll_cfg_slave.sv
module tb_fll_cfg_slave;

  localparam logic [31:0] CFG1_RST = 32'h0000_05F5;
  localparam logic [31:0] CFG2_RST = 32'h0040_0C44;

  logic        HCLK, HRESETn;
  logic        req_i, wrn_i;
  logic [1:0]  add_i;
  logic [31:0] data_i;
  logic        ack_o, lock_o;
  logic [31:0] r_data_o;
  logic [15:0] meas_cnt_i;
  logic        meas_valid_i;
  logic [31:0] integ_i;
  logic        integ_load_o;
  logic [31:0] integ_load_data_o;
  logic [15:0] mult_o;
  logic [9:0]  dco_code_o;
  logic [3:0]  clk_div_o;
  logic        open_loop_o, mode_o;
  logic [3:0]  gain_o;

  fll_cfg_slave #(.CFG1_RST(CFG1_RST), .CFG2_RST(CFG2_RST)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_i(req_i), .wrn_i(wrn_i), .add_i(add_i), .data_i(data_i),
    .ack_o(ack_o), .r_data_o(r_data_o), .lock_o(lock_o),
    .meas_cnt_i(meas_cnt_i), .meas_valid_i(meas_valid_i), .integ_i(integ_i),
    .integ_load_o(integ_load_o), .integ_load_data_o(integ_load_data_o),
    .mult_o(mult_o), .dco_code_o(dco_code_o), .clk_div_o(clk_div_o),
    .open_loop_o(open_loop_o), .mode_o(mode_o), .gain_o(gain_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, expressed in terms of the register map.
  logic [31:0] mcfg1, mcfg2;
  logic [15:0] mmeas;
  int          mlock, mhit, mmiss;

  int          pulse_cnt;
  logic [31:0] pulse_data;

  always @(negedge HCLK) begin
    if (integ_load_o === 1'b1) begin
      pulse_cnt++;
      pulse_data = integ_load_data_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 32'h%08h expected 32'h%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mcfg1 = CFG1_RST;
    mcfg2 = CFG2_RST & 32'h0FFF_FFFF;
    mmeas = 16'h0;
    mlock = 0; mhit = 0; mmiss = 0;
  endtask

  task automatic model_meas(input int m);
    int mult, diff, tol, thr;
    bit in_tol;
    mmeas = 16'(m);
    if (mcfg1[30]) return;
    mult   = int'(mcfg1[15:0]);
    diff   = (m > mult) ? m - mult : mult - m;
    tol    = int'(mcfg2[27:16]);
    in_tol = (diff <= tol);
    if (mlock == 0) begin
      thr = (mcfg2[9:4] == 0) ? 1 : int'(mcfg2[9:4]);
      if (!in_tol) mhit = 0;
      else begin
        mhit = (mhit < 63) ? mhit + 1 : 63;
        if (mhit >= thr) begin mlock = 1; mhit = 0; end
      end
    end else begin
      thr = (mcfg2[15:10] == 0) ? 1 : int'(mcfg2[15:10]);
      if (in_tol) mmiss = 0;
      else begin
        mmiss = (mmiss < 63) ? mmiss + 1 : 63;
        if (mmiss >= thr) begin mlock = 0; mmiss = 0; end
      end
    end
  endtask

  // One complete 4-phase transaction; optionally checks the 3-edge latencies.
  task automatic access(input logic wr_n, input logic [1:0] a, input logic [31:0] d,
                        output logic [31:0] rd, input bit chk_lat);
    int n;
    @(negedge HCLK);
    wrn_i = wr_n; add_i = a; data_i = d; req_i = 1'b1;
    n = 0;
    while (ack_o !== 1'b1 && n < 20) begin @(posedge HCLK); #1; n++; end
    chk("ack_rise", {31'h0, ack_o}, 32'h1);
    if (chk_lat) chk("ack_rise_latency", n, 3);
    rd = r_data_o;
    @(negedge HCLK);
    chk("rdata_stable", r_data_o, rd);
    req_i = 1'b0;
    n = 0;
    while (ack_o !== 1'b0 && n < 20) begin @(posedge HCLK); #1; n++; end
    chk("ack_fall", {31'h0, ack_o}, 32'h0);
    if (chk_lat) chk("ack_fall_latency", n, 3);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d, input bit chk_lat);
    logic [31:0] rd;
    access(1'b0, a, d, rd, chk_lat);
    if (a == 2'd1) begin
      mcfg1 = d;
      if (d[30]) begin mlock = 0; mhit = 0; mmiss = 0; end
    end else if (a == 2'd2) begin
      mcfg2 = {4'h0, d[27:0]};
    end
  endtask

  task automatic do_read(input logic [1:0] a, input string tag);
    logic [31:0] rd, exp;
    if (a == 2'd3) integ_i = $urandom;
    access(1'b1, a, $urandom, rd, 1'b0);
    case (a)
      2'd0: exp = {15'h0, mlock[0], mmeas};
      2'd1: exp = mcfg1;
      2'd2: exp = mcfg2;
      default: exp = integ_i;
    endcase
    chk(tag, rd, exp);
  endtask

  task automatic chk_outs();
    chk("mult_o", {16'h0, mult_o}, {16'h0, mcfg1[15:0]});
    chk("dco_code_o", {22'h0, dco_code_o}, {22'h0, mcfg1[25:16]});
    chk("clk_div_o", {28'h0, clk_div_o}, {28'h0, mcfg1[29:26]});
    chk("open_loop_o", {31'h0, open_loop_o}, {31'h0, mcfg1[30]});
    chk("mode_o", {31'h0, mode_o}, {31'h0, mcfg1[31]});
    chk("gain_o", {28'h0, gain_o}, {28'h0, mcfg2[3:0]});
    chk("lock_o", {31'h0, lock_o}, mlock);
  endtask

  task automatic strobe(input int m, input string tag);
    @(negedge HCLK);
    meas_cnt_i = 16'(m); meas_valid_i = 1'b1;
    @(negedge HCLK);
    meas_valid_i = 1'b0;
    model_meas(m);
    chk(tag, {31'h0, lock_o}, mlock);
  endtask

  initial begin
    logic [31:0] rd;
    int n, mult, tol, off;
    HRESETn = 1'b0; req_i = 1'b0; wrn_i = 1'b0; add_i = 2'd0; data_i = 32'h0;
    meas_cnt_i = 16'h0; meas_valid_i = 1'b0; integ_i = 32'h0;
    pulse_cnt = 0; pulse_data = 32'h0;
    model_reset();

    // Reset state.
    #12;
    chk("rst_ack", {31'h0, ack_o}, 32'h0);
    chk("rst_lock", {31'h0, lock_o}, 32'h0);
    chk("rst_rdata", r_data_o, 32'h0);
    chk("rst_integ_load", {31'h0, integ_load_o}, 32'h0);
    chk("rst_integ_data", integ_load_data_o, 32'h0);
    @(negedge HCLK); HRESETn = 1'b1;
    chk_outs();
    do_read(2'd1, "rst_cfg1_read");
    do_read(2'd2, "rst_cfg2_read");

    // CFG1 write with latency check, field decode and read-back.
    do_write(2'd1, 32'h8123_0ABC, 1'b1);
    chk("mult_dir", {16'h0, mult_o}, 32'h0000_0ABC);
    chk("dco_dir", {22'h0, dco_code_o}, 32'h0000_0123);
    chk("mode_dir", {31'h0, mode_o}, 32'h1);
    chk_outs();
    do_read(2'd1, "cfg1_readback");

    // Read-only / reserved bits.
    do_write(2'd2, 32'hF000_0000, 1'b0);
    do_read(2'd2, "cfg2_reserved");
    do_write(2'd0, 32'hFFFF_FFFF, 1'b0);
    do_read(2'd0, "status_ro");
    do_read(2'd3, "integ_read");

    // Directed lock sequence: mult=1000 tol=4 assert=3 deassert=2.
    do_write(2'd1, 32'h0000_03E8, 1'b0);
    do_write(2'd2, 32'h0004_0834, 1'b0);
    strobe(1003, "lock_s1");
    strobe(997,  "lock_s2");
    strobe(1004, "lock_s3");
    chk("lock_dir_set", {31'h0, lock_o}, 32'h1);
    strobe(1010, "lock_s4");
    strobe(1000, "lock_s5");
    chk("lock_dir_hold", {31'h0, lock_o}, 32'h1);
    strobe(1010, "lock_s6");
    strobe(990,  "lock_s7");
    chk("lock_dir_clear", {31'h0, lock_o}, 32'h0);
    do_read(2'd0, "status_after_lock");

    // Open loop forces lock off and freezes the detector.
    strobe(1000, "ol_pre1"); strobe(1000, "ol_pre2"); strobe(1000, "ol_pre3");
    do_write(2'd1, 32'h4000_03E8, 1'b0);
    chk("open_loop_unlock", {31'h0, lock_o}, 32'h0);
    for (int i = 0; i < 4; i++) strobe(1000, "ol_frozen");
    do_write(2'd1, 32'h0000_03E8, 1'b0);

    // Integrator load.
    pulse_cnt = 0;
    do_write(2'd3, 32'h0000_1234, 1'b0);
    repeat (2) @(negedge HCLK);
`ifdef FLL_CFG_INTEG_WR_EN
    chk("integ_pulses", pulse_cnt, 1);
    chk("integ_pulse_data", pulse_data, 32'h0000_1234);
    chk("integ_data_hold", integ_load_data_o, 32'h0000_1234);
`else
    chk("integ_pulses", pulse_cnt, 0);
    chk("integ_data_tied", integ_load_data_o, 32'h0);
`endif

    // Randomized register accesses.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0) do_write(2'($urandom_range(0, 3)), $urandom, 1'b0);
      else do_read(2'($urandom_range(0, 3)), "rand_read");
    end
    chk_outs();

    // Randomized lock detector runs.
    for (int r = 0; r < 4; r++) begin
      mult = $urandom_range(100, 60000);
      tol  = $urandom_range(0, 6);
      do_write(2'd1, {1'($urandom), 1'b0, 14'($urandom), 16'(mult)}, 1'b0);
      do_write(2'd2, {4'h0, 12'(tol), 6'($urandom_range(0, 4)), 6'($urandom_range(0, 4)),
                      4'($urandom)}, 1'b0);
      chk_outs();
      for (int k = 0; k < 40; k++) begin
        off = $urandom_range(0, 16);
        strobe(mult + off - 8, "rand_lock");
      end
      do_read(2'd0, "rand_status");
    end

    // Reset in the middle of a handshake.
    do_write(2'd1, 32'h1111_2222, 1'b0);
    @(negedge HCLK);
    wrn_i = 1'b1; add_i = 2'd1; req_i = 1'b1;
    n = 0;
    while (ack_o !== 1'b1 && n < 20) begin @(posedge HCLK); #1; n++; end
    chk("mid_ack_before", {31'h0, ack_o}, 32'h1);
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_ack", {31'h0, ack_o}, 32'h0);
    chk("mid_rst_mult", {16'h0, mult_o}, {16'h0, CFG1_RST[15:0]});
    chk("mid_rst_lock", {31'h0, lock_o}, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    n = 0;
    while (ack_o !== 1'b1 && n < 20) begin @(posedge HCLK); #1; n++; end
    chk("mid_reservice_ack", {31'h0, ack_o}, 32'h1);
    chk("mid_reservice_lat", n, 3);
    chk("mid_reservice_data", r_data_o, CFG1_RST);
    @(negedge HCLK);
    req_i = 1'b0;
    n = 0;
    while (ack_o !== 1'b0 && n < 20) begin @(posedge HCLK); #1; n++; end
    chk("mid_final_ack_low", {31'h0, ack_o}, 32'h0);
    chk_outs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
